// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer and its display scanner.
//   state_t        : timer control states
//   SEG_*          : active-low 7-segment codes, bit order {g,f,e,d,c,b,a}
//   bcd_digit_sub  : one BCD digit of a ripple-borrow subtractor
//   seg_decode     : nibble to 7-segment code, non-BCD nibbles show a dash
package timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Returns {borrow_out, diff}. A negative raw difference is corrected by
  // adding ten, which wraps the 4-bit result back into 0..9.
  function automatic logic [4:0] bcd_digit_sub(input logic [3:0] a,
                                               input logic [3:0] b,
                                               input logic       borrow_in);
    logic [4:0] raw;
    raw = {1'b0, a} - {1'b0, b} - {4'b0000, borrow_in};
    if (raw[4]) begin
      return {1'b1, raw[3:0] + 4'd10};
    end
    return {1'b0, raw[3:0]};
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/countdown_timer_mux_if.sv
// Bundle between the game FSM (master) and the countdown timer (slave).
//   start, miss, load      : control from the game FSM
//   value_bcd, game_fail   : timer status
//   seg, dp, an            : active-low 7-segment pin drive
interface countdown_timer_mux_if #(
  parameter int NUM_DIGITS = 8
);
  logic                      start;
  logic                      miss;
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   value_bcd;
  logic                      game_fail;
  logic [6:0]                seg;
  logic                      dp;
  logic [NUM_DIGITS-1:0]     an;

  modport master (
    output start, miss, load,
    input  value_bcd, game_fail, seg, dp, an
  );

  modport slave (
    input  start, miss, load,
    output value_bcd, game_fail, seg, dp, an
  );
endinterface

// File: rtl/seg7_scan.sv
// Time-multiplexed active-low 7-segment driver.
//   clock, reset : system clock, synchronous active-high reset
//   value_bcd    : packed BCD value to display, digit 0 in the low nibble
//   seg, dp, an  : registered segment, decimal-point and digit-enable outputs
// RESET_BCD supplies the digit shown straight out of reset, so the pins are
// valid before the first scan step.
module seg7_scan
  import timer_pkg::*;
#(
  parameter int          NUM_DIGITS = 8,
  parameter int          SCAN_DIV   = 2048,
  parameter int          DP_POS     = 4,
  parameter int          BLANK_LZ   = 0,
  parameter logic [31:0] RESET_BCD  = 32'h0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value_bcd,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [SW-1:0]         scan_cnt_reg;
  logic [IW-1:0]         digit_idx_reg;
  logic [6:0]            seg_reg, seg_next;
  logic                  dp_reg, dp_next;
  logic [NUM_DIGITS-1:0] an_reg, an_next;

  logic [3:0]            nibbles [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] upper_zero;  // bit i: nibble i and everything above is zero

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign nibbles[gi]    = value_bcd[4*gi +: 4];
    assign upper_zero[gi] = (value_bcd[4*NUM_DIGITS-1:4*gi] == '0);
  end

  always_comb begin
    seg_next = seg_decode(nibbles[digit_idx_reg]);
    if ((BLANK_LZ != 0) && (int'(digit_idx_reg) > DP_POS) && upper_zero[digit_idx_reg]) begin
      seg_next = SEG_BLANK;
    end
    dp_next = (int'(digit_idx_reg) == DP_POS) ? 1'b0 : 1'b1;
    an_next = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << digit_idx_reg);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      scan_cnt_reg  <= '0;
      digit_idx_reg <= '0;
      seg_reg       <= seg_decode(RESET_BCD[3:0]);
      dp_reg        <= (DP_POS == 0) ? 1'b0 : 1'b1;
      an_reg        <= ~{{(NUM_DIGITS-1){1'b0}}, 1'b1};
    end else begin
      if (scan_cnt_reg == SW'(SCAN_DIV - 1)) begin
        scan_cnt_reg  <= '0;
        digit_idx_reg <= (digit_idx_reg == IW'(NUM_DIGITS - 1)) ? '0 : digit_idx_reg + IW'(1);
      end else begin
        scan_cnt_reg  <= scan_cnt_reg + SW'(1);
      end
      seg_reg <= seg_next;
      dp_reg  <= dp_next;
      an_reg  <= an_next;
    end
  end

  assign seg = seg_reg;
  assign dp  = dp_reg;
  assign an  = an_reg;

endmodule

// File: rtl/countdown_timer_mux.sv
// BCD countdown timer with run/pause/reload, saturating miss penalty,
// sticky expiry flag and a multiplexed 7-segment display.
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : start/miss/load in; value_bcd, game_fail, seg, dp, an out
module countdown_timer_mux
  import timer_pkg::*;
#(
  parameter int          CLK_DIV     = 5000,
  parameter int          NUM_DIGITS  = 8,
  parameter logic [31:0] START_VALUE = 32'h0180_0000,
  parameter logic [31:0] PENALTY     = 32'h0001_0000,
  parameter int          SCAN_DIV    = 2048,
  parameter int          DP_POS      = 4,
  parameter int          BLANK_LZ    = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  countdown_timer_mux_if.slave  bus
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] START_BCD   = START_VALUE[W-1:0];
  localparam logic [W-1:0] PENALTY_BCD = PENALTY[W-1:0];

  state_t        state_reg;
  logic [W-1:0]  value_reg, value_next;
  logic          fail_reg;
  logic [PW-1:0] presc_reg;
  logic          miss_q_reg;

  logic          tick, miss_edge, dec_en, hits_zero, borrow;
  logic [W-1:0]  sub_bcd;

  assign tick      = (state_reg == RUN) && (presc_reg == PW'(CLK_DIV - 1));
  assign miss_edge = bus.miss && !miss_q_reg && ((state_reg == RUN) || (state_reg == PAUSE));
  assign dec_en    = tick || miss_edge;

  // The tick enters as the chain's initial borrow, so value - penalty - tick
  // is one ripple pass. A final borrow means value < d; a zero result means
  // value == d; both saturate to zero.
  always_comb begin
    borrow  = tick;
    sub_bcd = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      {borrow, sub_bcd[4*i +: 4]} = bcd_digit_sub(value_reg[4*i +: 4],
                                                  miss_edge ? PENALTY_BCD[4*i +: 4] : 4'd0,
                                                  borrow);
    end
    value_next = (borrow || (sub_bcd == '0)) ? '0 : sub_bcd;
    hits_zero  = (value_next == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      value_reg  <= START_BCD;
      fail_reg   <= 1'b0;
      presc_reg  <= '0;
      miss_q_reg <= 1'b0;
    end else begin
      miss_q_reg <= bus.miss;
      if (bus.load) begin
        state_reg <= IDLE;
        value_reg <= START_BCD;
        fail_reg  <= 1'b0;
        presc_reg <= '0;
      end else begin
        if (state_reg == RUN) begin
          presc_reg <= tick ? '0 : presc_reg + PW'(1);
        end
        if (dec_en) begin
          value_reg <= value_next;
        end
        case (state_reg)
          IDLE: begin
            if (bus.start) state_reg <= RUN;
          end
          RUN: begin
            if (dec_en && hits_zero) begin
              state_reg <= EXPIRED;
              fail_reg  <= 1'b1;
            end else if (!bus.start) begin
              state_reg <= PAUSE;
            end
          end
          PAUSE: begin
            if (dec_en && hits_zero) begin
              state_reg <= EXPIRED;
              fail_reg  <= 1'b1;
            end else if (bus.start) begin
              state_reg <= RUN;
            end
          end
          EXPIRED: begin
            state_reg <= EXPIRED;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign bus.value_bcd = value_reg;
  assign bus.game_fail = fail_reg;

  seg7_scan #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV),
    .DP_POS     (DP_POS),
    .BLANK_LZ   (BLANK_LZ),
    .RESET_BCD  (START_VALUE)
  ) u_scan (
    .clock     (clock),
    .reset     (reset),
    .value_bcd (value_reg),
    .seg       (bus.seg),
    .dp        (bus.dp),
    .an        (bus.an)
  );

endmodule

// File: tb/tb_countdown_timer_mux.sv
// Bench for countdown_timer_mux: a phase table of held inputs with expected
// end-of-phase values, a per-cycle reference model feeding a scoreboard
// queue, and a hand-written display scan sequence.
module tb_countdown_timer_mux;

  localparam int ND       = 4;
  localparam int CLK_DIV  = 4;
  localparam int SCAN_DIV = 4;
  localparam int DP_POS   = 2;
  localparam int START_I  = 12;
  localparam int PEN_I    = 10;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  countdown_timer_mux_if #(.NUM_DIGITS(ND)) bus ();

  countdown_timer_mux #(
    .CLK_DIV     (CLK_DIV),
    .NUM_DIGITS  (ND),
    .START_VALUE (32'h0000_0012),
    .PENALTY     (32'h0000_0010),
    .SCAN_DIV    (SCAN_DIV),
    .DP_POS      (DP_POS),
    .BLANK_LZ    (1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] val;
    bit          fail;
    logic [6:0]  seg;
    bit          dp;
    logic [3:0]  an;
  } exp_t;

  typedef struct {
    bit          rst, ld, st, ms;
    int          cycles;
    logic [15:0] exp_val;
    bit          exp_fail;
    string       name;
  } vec_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // reference model state (0 IDLE, 1 RUN, 2 PAUSE, 3 EXPIRED)
  int m_state, m_presc, m_val, m_fail, m_missq, sc_cnt, sc_idx;

  function automatic logic [6:0] ref_code(int dgt);
    case (dgt)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] ref_seg(int v, int idx);
    int p = 1;
    for (int k = 0; k < idx; k++) p = p * 10;
    if (idx > DP_POS && (v / p) == 0) return 7'h7F;
    return ref_code((v / p) % 10);
  endfunction

  function automatic logic [3:0] ref_an(int idx);
    logic [3:0] one = 4'b0001;
    return ~(one << idx);
  endfunction

  task automatic model_step(input bit r, input bit l, input bit s, input bit m, output exp_t e);
    bit tick, edg, hit;
    int d;
    if (r) begin
      m_state = 0; m_presc = 0; m_val = START_I; m_fail = 0; m_missq = 0;
      sc_cnt = 0; sc_idx = 0;
      e.seg = ref_code(START_I % 10); e.dp = 1'b1; e.an = 4'b1110;
    end else begin
      e.seg = ref_seg(m_val, sc_idx);
      e.dp  = (sc_idx == DP_POS) ? 1'b0 : 1'b1;
      e.an  = ref_an(sc_idx);
      if (sc_cnt == SCAN_DIV - 1) begin sc_cnt = 0; sc_idx = (sc_idx + 1) % ND; end
      else sc_cnt++;
      tick = (m_state == 1) && (m_presc == CLK_DIV - 1);
      edg  = m && !m_missq && (m_state == 1 || m_state == 2);
      m_missq = m;
      if (l) begin
        m_state = 0; m_val = START_I; m_fail = 0; m_presc = 0;
      end else begin
        d = (tick ? 1 : 0) + (edg ? PEN_I : 0);
        hit = 0;
        if (m_state == 1) m_presc = tick ? 0 : m_presc + 1;
        if (d > 0) begin
          m_val = (m_val > d) ? m_val - d : 0;
          hit = (m_val == 0);
        end
        case (m_state)
          0: if (s) m_state = 1;
          1: if (hit) begin m_state = 3; m_fail = 1; end else if (!s) m_state = 2;
          2: if (hit) begin m_state = 3; m_fail = 1; end else if (s) m_state = 1;
          default: ;
        endcase
      end
    end
    e.val  = to_bcd(m_val);
    e.fail = (m_fail != 0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // drive one cycle, push the model's prediction, then pop and compare
  task automatic cycle(input bit r, input bit l, input bit s, input bit m);
    exp_t e, got;
    reset = r; bus.load = l; bus.start = s; bus.miss = m;
    model_step(r, l, s, m, e);
    sbq.push_back(e);
    @(posedge clock);
    #1;
    cyc++;
    got = sbq.pop_front();
    check("sb_value", 32'(bus.value_bcd), 32'(got.val));
    check("sb_fail",  32'(bus.game_fail), 32'(got.fail));
    check("sb_seg",   32'(bus.seg),       32'(got.seg));
    check("sb_dp",    32'(bus.dp),        32'(got.dp));
    check("sb_an",    32'(bus.an),        32'(got.an));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  vec_t vecs[16];
  logic [3:0] scan_an  [4];
  logic [6:0] scan_seg [4];
  bit         scan_dp  [4];

  initial begin
    vecs[0]  = '{0, 0, 1, 0, 13, 16'h0009, 0, "run_borrow"};
    vecs[1]  = '{0, 1, 0, 0, 1,  16'h0012, 0, "load"};
    vecs[2]  = '{0, 0, 1, 0, 5,  16'h0011, 0, "run_to_11"};
    vecs[3]  = '{0, 0, 1, 1, 1,  16'h0001, 0, "miss_pulse"};
    vecs[4]  = '{0, 0, 0, 1, 20, 16'h0001, 0, "miss_held_pause"};
    vecs[5]  = '{0, 0, 1, 0, 3,  16'h0000, 1, "resume_retained"};
    vecs[6]  = '{0, 0, 1, 0, 8,  16'h0000, 1, "expired_hold"};
    vecs[7]  = '{0, 1, 0, 0, 1,  16'h0012, 0, "load_expired"};
    vecs[8]  = '{0, 0, 1, 0, 5,  16'h0011, 0, "run_to_11b"};
    vecs[9]  = '{0, 0, 1, 0, 3,  16'h0011, 0, "pre_tick"};
    vecs[10] = '{0, 0, 1, 1, 1,  16'h0000, 1, "miss_and_tick"};
    vecs[11] = '{0, 0, 1, 0, 10, 16'h0000, 1, "sat_hold"};
    vecs[12] = '{0, 1, 0, 0, 1,  16'h0012, 0, "load2"};
    vecs[13] = '{0, 0, 0, 1, 1,  16'h0012, 0, "miss_idle"};
    vecs[14] = '{0, 0, 1, 0, 29, 16'h0005, 0, "run_to_5"};
    vecs[15] = '{1, 0, 1, 0, 1,  16'h0012, 0, "reset_mid_run"};

    scan_an[0] = 4'b1110; scan_seg[0] = 7'b0100100; scan_dp[0] = 1;
    scan_an[1] = 4'b1101; scan_seg[1] = 7'b1111001; scan_dp[1] = 1;
    scan_an[2] = 4'b1011; scan_seg[2] = 7'b1000000; scan_dp[2] = 0;
    scan_an[3] = 4'b0111; scan_seg[3] = 7'h7F;      scan_dp[3] = 1;

    bus.start = 0; bus.miss = 0; bus.load = 0;
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("reset_value", 32'(bus.value_bcd), 32'h0012);
    check("reset_fail",  32'(bus.game_fail), 32'h0);
    check("reset_an",    32'(bus.an),        32'hE);

    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].cycles; c++)
        cycle(vecs[i].rst, vecs[i].ld, vecs[i].st, vecs[i].ms);
      check({vecs[i].name, "_value"}, 32'(bus.value_bcd), 32'(vecs[i].exp_val));
      check({vecs[i].name, "_fail"},  32'(bus.game_fail), 32'(vecs[i].exp_fail));
      $display("phase %0d %s value=%h fail=%0d", i, vecs[i].name, bus.value_bcd, bus.game_fail);
    end

    // reset just landed: digit 0 shows now, each further digit 4 cycles later
    check("scan0_an",  32'(bus.an),  32'(scan_an[0]));
    check("scan0_seg", 32'(bus.seg), 32'(scan_seg[0]));
    check("scan0_dp",  32'(bus.dp),  32'(scan_dp[0]));
    for (int k = 1; k <= 13; k++) begin
      cycle(0, 0, 0, 0);
      if (k % 4 == 1 && k > 1) begin
        check("scan_an",  32'(bus.an),  32'(scan_an[k / 4]));
        check("scan_seg", 32'(bus.seg), 32'(scan_seg[k / 4]));
        check("scan_dp",  32'(bus.dp),  32'(scan_dp[k / 4]));
        $display("scan digit %0d an=%b seg=%b dp=%0d", k / 4, bus.an, bus.seg, bus.dp);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
